dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 53 +++++
 rtl/dmem_ram.sv | 29 ++
 rtl/dmem_ctrl.sv | 112 +++++++++++
 tb/tb_dmem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared size encodings and lane helpers for the data-memory controller.
// Helpers work on a 64-bit lane view; callers cast down to their DATA_W.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  function automatic logic [2:0] size_mask(size_e size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] be_gen(size_e size, logic [2:0] offset);
    logic [7:0] ones;
    case (size)
      SZ_B:    ones = 8'h01;
      SZ_H:    ones = 8'h03;
      SZ_W:    ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ones << offset;
  endfunction

  function automatic logic [63:0] st_replicate(size_e size, logic [63:0] wdata);
    case (size)
      SZ_B:    return {8{wdata[7:0]}};
      SZ_H:    return {4{wdata[15:0]}};
      SZ_W:    return {2{wdata[31:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [63:0] ld_extract(logic [63:0] word, logic [2:0] offset,
                                              size_e size, logic sgn);
    logic [63:0] sh;
    sh = word >> {offset, 3'b000};
    case (size)
      SZ_B:    return {{56{sgn & sh[7]}}, sh[7:0]};
      SZ_H:    return {{48{sgn & sh[15]}}, sh[15:0]};
      SZ_W:    return {{32{sgn & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port RAM, per-byte write enable, gated synchronous read, no reset.
module dmem_ram #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 2048,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [NB-1:0]     be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (re_i) rdata_q <= mem_q[addr_i];
    for (int unsigned b = 0; b < NB; b++) begin
      if (we_i && be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request in, single registered response out.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned AW    = ADDR_W - OFF_W;
  localparam int unsigned DEPTH = 2 ** AW;

  size_e             size;
  logic [2:0]        off_raw, mask, off_al;
  logic              size_ok, err, accept, ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  logic       vld_q, vld_d, err_q, err_d, st_q, st_d, sgn_q, sgn_d;
  logic [2:0] off_q, off_d;
  size_e      size_q, size_d;

  assign size    = size_e'(req_size);
  assign off_raw = 3'(req_addr[OFF_W-1:0]);
  assign mask    = size_mask(size);
  assign off_al  = off_raw & ~mask;
  assign size_ok = (size != SZ_D) || (DATA_W == 64);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign err = !size_ok || (|(off_raw & mask));
`else
  assign err = !size_ok;
`endif

  // Rst_n gates accept so no RAM write slips through while reset is held.
  assign req_ready = !vld_q || rsp_ready;
  assign accept    = req_valid && req_ready && Rst_n;
  assign ram_we    = accept && req_we && !err;
  assign ram_re    = accept && !req_we;

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .Clk     (Clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (req_addr[ADDR_W-1:OFF_W]),
    .be_i    (NB'(be_gen(size, off_al))),
    .wdata_i (DATA_W'(st_replicate(size, 64'(req_wdata)))),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    vld_d  = vld_q;
    err_d  = err_q;
    st_d   = st_q;
    off_d  = off_q;
    size_d = size_q;
    sgn_d  = sgn_q;
    if (accept) begin
      vld_d  = 1'b1;
      err_d  = err;
      st_d   = req_we;
      off_d  = off_al;
      size_d = size;
      sgn_d  = req_signed;
    end else if (rsp_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      st_q   <= 1'b0;
      off_q  <= '0;
      size_q <= SZ_B;
      sgn_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      st_q   <= st_d;
      off_q  <= off_d;
      size_q <= size_d;
      sgn_q  <= sgn_d;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_err   = vld_q && err_q;
  assign rsp_rdata = (vld_q && !err_q && !st_q)
                   ? DATA_W'(ld_extract(64'(ram_rdata), off_q, size_q, sgn_q))
                   : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl against a byte-array memory model.
module tb_dmem_ctrl;

  localparam int DW = 32;
  localparam int AW = 13;

  logic          Clk = 1'b0, Rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;

  dmem_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [0:8191];
  int         checks = 0, errors = 0, pops = 0;
  int         bp_mode = 1;  // 0 random, 1 always ready, 2 stalled
  bit         bp_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, natural alignment, sign/zero fill.
  function automatic void model(input bit we, input int addr, input int size,
                                input bit sgn, input logic [31:0] wd);
    exp_t        e;
    int          nb, base;
    bit          err;
    logic [63:0] v;
    nb   = 1 << size;
    err  = (size == 3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((addr % nb) != 0) err = 1;
`endif
    base = addr - (addr % nb);
    v    = '0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (we) mem[base + i] = wd[8*i +: 8];
        else    v = v | (64'(mem[base + i]) << (8 * i));
      end
      if (!we && sgn && v[8*nb - 1]) v = v | ~((64'd1 << (8 * nb)) - 1);
    end
    e.e = err;
    e.d = (err || we) ? '0 : v[DW-1:0];
    exp_q.push_back(e);
  endfunction

  // Called and returns at posedge+1; inputs held until accepted.
  task automatic issue(input bit we, input int addr, input int size,
                       input bit sgn, input logic [31:0] wd);
    bit done  = 0;
    int guard = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr[AW-1:0];
    req_size   = size[1:0];
    req_signed = sgn;
    req_wdata  = wd;
    while (!done) begin
      @(negedge Clk);
      if (req_ready) begin
        model(we, addr, size, sgn, wd);
        done = 1;
      end
      @(posedge Clk); #1;
      guard++;
      if (!done && guard > 200) begin
        checks++; errors++;
        $display("FAIL issue_timeout addr=%h actual=stalled required=accepted", addr);
        done = 1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge Clk);
      g++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge Clk); #1;
  endtask

  always @(posedge Clk) begin
    #1;
    case (bp_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      2:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  // Monitor: every presented response must match the head of the queue.
  always @(negedge Clk) begin
    if (Rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected actual=%h required=no_response", rsp_rdata);
      end else begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].d));
        chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].e));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    int p0, g;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    issue(1, 'h10, 2, 0, 32'h11223344);
    issue(1, 'h11, 0, 0, 32'h000000AA);
    issue(0, 'h10, 2, 0, 0);
    issue(0, 'h11, 0, 1, 0);
    issue(0, 'h11, 0, 0, 0);
    issue(1, 'h22, 1, 0, 32'h00008001);
    issue(0, 'h22, 1, 1, 0);
    issue(0, 'h22, 1, 0, 0);
    issue(0, 'h20, 2, 0, 0);
    issue(1, 'h40, 2, 0, 32'hDEADBEEF);
    issue(0, 'h40, 2, 0, 0);
    issue(0, 'h42, 2, 0, 0);
    issue(1, 'h42, 2, 0, 32'h55667788);
    issue(0, 'h40, 2, 0, 0);
    issue(0, 'h40, 3, 0, 0);
    issue(1, 'h40, 3, 0, 32'h12345678);
    issue(0, 'h40, 2, 1, 0);
    drain();

    bp_mode = 2;
    bp_done = 0;
    fork
      begin
        issue(0, 'h10, 2, 0, 0);
        issue(0, 'h20, 2, 0, 0);
        issue(0, 'h40, 2, 0, 0);
        issue(0, 'h11, 0, 1, 0);
        bp_done = 1;
      end
    join_none
    @(posedge Clk);
    repeat (3) begin
      @(negedge Clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    bp_mode = 1;
    p0 = pops;
    repeat (4) @(negedge Clk);
    #1;
    chk("bp_burst_pops", 64'(pops - p0), 64'd4);
    g = 0;
    while (!bp_done && g < 100) begin
      @(posedge Clk);
      g++;
    end
    chk("bp_driver_done", 64'(bp_done), 64'd1);
    #1;
    drain();

    for (int a = 'h100; a < 'h200; a += 4) issue(1, a, 2, 0, $urandom);
    bp_mode = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge Clk); #1;
      end
      issue($urandom_range(0, 2) == 0, 'h100 + $urandom_range(0, 255),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom);
    end
    bp_mode = 1;
    drain();

    bp_mode = 2;
    issue(0, 'h10, 2, 0, 0);
    #2;
    chk("rstmid_valid_before", 64'(rsp_valid), 64'd1);
    Rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid_rdata", 64'(rsp_rdata), 64'd0);
    chk("rstmid_err", 64'(rsp_err), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    bp_mode = 1;
    #1;
    chk("rstmid_req_ready", 64'(req_ready), 64'd1);
    @(posedge Clk); #1;
    issue(0, 'h10, 2, 0, 0);
    issue(0, 'h11, 0, 0, 0);
    issue(0, 'h22, 1, 1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
